// File: rtl/wave_voice_bank.sv
// wave_voice_bank: multi-voice quarter-wave oscillator bank with one time-shared ROM pipeline and a saturating mixer.
// Define WAVE_CLIP_COUNT_EN to build the saturation event counter behind clip_count.

// Quarter-wave ROMs with one-cycle registered read. They hold the linear characterisation table
// {0, addr, 0...}; production tables drop in behind the same ports.
module sine_rom #(
    parameter int LUT_AW   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [LUT_AW-1:0]   i_addr,
    output logic [SAMPLE_W-1:0] o_data
);
    logic [SAMPLE_W-1:0] r_data;

    // Registered table lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= {SAMPLE_W{1'b0}};
        end else begin
            r_data <= {1'b0, i_addr, {(SAMPLE_W-1-LUT_AW){1'b0}}};
        end
    end

    assign o_data = r_data;
endmodule

module square_rom #(
    parameter int LUT_AW   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [LUT_AW-1:0]   i_addr,
    output logic [SAMPLE_W-1:0] o_data
);
    logic [SAMPLE_W-1:0] r_data;

    // Registered table lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= {SAMPLE_W{1'b0}};
        end else begin
            r_data <= {1'b0, i_addr, {(SAMPLE_W-1-LUT_AW){1'b0}}};
        end
    end

    assign o_data = r_data;
endmodule

module triangle_rom #(
    parameter int LUT_AW   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [LUT_AW-1:0]   i_addr,
    output logic [SAMPLE_W-1:0] o_data
);
    logic [SAMPLE_W-1:0] r_data;

    // Registered table lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= {SAMPLE_W{1'b0}};
        end else begin
            r_data <= {1'b0, i_addr, {(SAMPLE_W-1-LUT_AW){1'b0}}};
        end
    end

    assign o_data = r_data;
endmodule

module wave_voice_bank #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 22,
    parameter int STEP_W     = 20,
    parameter int LUT_AW     = 10,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [STEP_W-1:0]             cfg_step,
    input  logic [1:0]                    cfg_wave,
    input  logic                          cfg_enable,
    input  logic                          cfg_restart,
    input  logic                          generate_next,
    output logic                          busy,
    output logic                          sample_ready,
    output logic [SAMPLE_W-1:0]           sample,
    output logic                          overrun,
    output logic [7:0]                    clip_count
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VOICES - 1);
    localparam logic [VW-1:0] IDX_ONE  = VW'(1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [VW-1:0]           r_idx;
    logic [PHASE_W-1:0]      r_phase [NUM_VOICES];
    logic [STEP_W-1:0]       r_step  [NUM_VOICES];
    logic [1:0]              r_wave  [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_enable;
    logic                    r_d_valid;
    logic                    r_d_neg;
    logic                    r_d_en;
    logic [1:0]              r_d_wave;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_overrun;
    logic [SAMPLE_W-1:0]     r_sample;
    logic                    w_accept;
    logic [LUT_AW-1:0]       w_addr;
    logic [SAMPLE_W-1:0]     w_sine;
    logic [SAMPLE_W-1:0]     w_square;
    logic [SAMPLE_W-1:0]     w_triangle;
    logic [SAMPLE_W-1:0]     w_rom_word;
    logic signed [ACC_W-1:0] w_word_ext;
    logic signed [ACC_W-1:0] w_voice;
    logic signed [ACC_W-1:0] w_scaled;

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic [SAMPLE_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[SAMPLE_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[SAMPLE_W-1:0];
        end else begin
            return v[SAMPLE_W-1:0];
        end
    endfunction

    assign w_accept = generate_next && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_scaled = r_acc >>> GAIN_SHIFT;

    // Next-state logic; DONE accepts a new request so results can run back to back.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_ISSUE;
                else          w_state_next = S_IDLE;
            end
            S_ISSUE: begin
                if (r_idx == LAST_IDX) w_state_next = S_DRAIN;
                else                   w_state_next = S_ISSUE;
            end
            S_DRAIN: w_state_next = S_DONE;
            S_DONE: begin
                if (w_accept) w_state_next = S_ISSUE;
                else          w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and issue index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= {VW{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx <= {VW{1'b0}};
            end else if (r_state == S_ISSUE) begin
                r_idx <= r_idx + IDX_ONE;
            end
        end
    end

    // Quadrant folding: bits below the top two address the table, mirrored in odd quadrants.
    always_comb begin
        if (r_phase[r_idx][PHASE_W-2]) begin
            w_addr = ~r_phase[r_idx][PHASE_W-3 -: LUT_AW];
        end else begin
            w_addr = r_phase[r_idx][PHASE_W-3 -: LUT_AW];
        end
    end

    // Voice configuration and phase accumulators; restart overrides a coincident advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= {PHASE_W{1'b0}};
                r_step[v]  <= {STEP_W{1'b0}};
                r_wave[v]  <= 2'b00;
            end
            r_enable <= {NUM_VOICES{1'b0}};
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cfg_we && (cfg_voice == VW'(v))) begin
                    r_step[v]   <= cfg_step;
                    r_wave[v]   <= cfg_wave;
                    r_enable[v] <= cfg_enable;
                end
                if (cfg_we && cfg_restart && (cfg_voice == VW'(v))) begin
                    r_phase[v] <= {PHASE_W{1'b0}};
                end else if ((r_state == S_ISSUE) && (r_idx == VW'(v))) begin
                    r_phase[v] <= r_phase[v] + PHASE_W'(r_step[v]);
                end else begin
                    r_phase[v] <= r_phase[v];
                end
            end
        end
    end

    sine_rom #(.LUT_AW(LUT_AW), .SAMPLE_W(SAMPLE_W)) u_sine_rom (
        .i_clk(clk), .i_rst_n(reset), .i_addr(w_addr), .o_data(w_sine)
    );
    square_rom #(.LUT_AW(LUT_AW), .SAMPLE_W(SAMPLE_W)) u_square_rom (
        .i_clk(clk), .i_rst_n(reset), .i_addr(w_addr), .o_data(w_square)
    );
    triangle_rom #(.LUT_AW(LUT_AW), .SAMPLE_W(SAMPLE_W)) u_triangle_rom (
        .i_clk(clk), .i_rst_n(reset), .i_addr(w_addr), .o_data(w_triangle)
    );

    // Voice attributes delayed to line up with the ROM output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_valid <= 1'b0;
            r_d_neg   <= 1'b0;
            r_d_en    <= 1'b0;
            r_d_wave  <= 2'b00;
        end else begin
            r_d_valid <= (r_state == S_ISSUE);
            r_d_neg   <= r_phase[r_idx][PHASE_W-1];
            r_d_en    <= r_enable[r_idx];
            r_d_wave  <= r_wave[r_idx];
        end
    end

    // Waveform select on the delayed voice.
    always_comb begin
        case (r_d_wave)
            2'b11:   w_rom_word = w_square;
            2'b10:   w_rom_word = w_triangle;
            default: w_rom_word = w_sine;
        endcase
    end

    assign w_word_ext = {{(ACC_W-SAMPLE_W){w_rom_word[SAMPLE_W-1]}}, w_rom_word};

    // Second half of the cycle negates; disabled voices add nothing.
    always_comb begin
        w_voice = {ACC_W{1'b0}};
        if (r_d_en) begin
            if (r_d_neg) w_voice = -w_word_ext;
            else         w_voice = w_word_ext;
        end else begin
            w_voice = {ACC_W{1'b0}};
        end
    end

    // Mix accumulator, cleared when a request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (w_accept) begin
            r_acc <= {ACC_W{1'b0}};
        end else if (r_d_valid) begin
            r_acc <= r_acc + w_voice;
        end
    end

    // Registered handshake, result and sticky overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_sample  <= {SAMPLE_W{1'b0}};
            r_overrun <= 1'b0;
        end else begin
            r_busy  <= (w_state_next == S_ISSUE) || (w_state_next == S_DRAIN);
            r_ready <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_sample <= sat_clamp(w_scaled);
            end
            if (generate_next && r_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign busy         = r_busy;
    assign sample_ready = r_ready;
    assign sample       = r_sample;
    assign overrun      = r_overrun;

`ifdef WAVE_CLIP_COUNT_EN
    logic [7:0] r_clip_count;

    // Count results altered by clamping, holding at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clip_count <= 8'd0;
        end else if ((r_state == S_DONE) && sat_hit(w_scaled) && (r_clip_count != 8'hFF)) begin
            r_clip_count <= r_clip_count + 8'd1;
        end
    end

    assign clip_count = r_clip_count;
`else
    assign clip_count = 8'd0;
`endif
endmodule

// File: tb/tb_wave_voice_bank.sv
// Scoreboard bench for wave_voice_bank: dut_a (GAIN_SHIFT=0) and dut_b (GAIN_SHIFT=2) share one stimulus
// stream; each request pushes hand-computed results, a negedge monitor pops and compares them.
module tb_wave_voice_bank;
    typedef struct {
        int   value;
        int   at;
        logic busy;
    } exp_t;

    logic        clk           = 1'b0;
    logic        reset         = 1'b0;
    logic        cfg_we        = 1'b0;
    logic [1:0]  cfg_voice     = 2'd0;
    logic [19:0] cfg_step      = 20'd0;
    logic [1:0]  cfg_wave      = 2'd0;
    logic        cfg_enable    = 1'b0;
    logic        cfg_restart   = 1'b0;
    logic        generate_next = 1'b0;

    logic [1:0]       bsy;
    logic [1:0]       rdy;
    logic [1:0]       ovr;
    logic [1:0][15:0] smp;
    logic [1:0][7:0]  clp;

    exp_t q[2][$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    int qa[6] = '{0, 16384, 32736, 16352, 0, -16384};
    int qb[6] = '{0, 4096, 8184, 4088, 0, -4096};

`ifdef WAVE_CLIP_COUNT_EN
    localparam int CLIP_A = 3;
`else
    localparam int CLIP_A = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wave_voice_bank #(.GAIN_SHIFT(0)) dut_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_step(cfg_step),
        .cfg_wave(cfg_wave), .cfg_enable(cfg_enable), .cfg_restart(cfg_restart),
        .generate_next(generate_next), .busy(bsy[0]), .sample_ready(rdy[0]), .sample(smp[0]),
        .overrun(ovr[0]), .clip_count(clp[0])
    );

    wave_voice_bank dut_b (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_step(cfg_step),
        .cfg_wave(cfg_wave), .cfg_enable(cfg_enable), .cfg_restart(cfg_restart),
        .generate_next(generate_next), .busy(bsy[1]), .sample_ready(rdy[1]), .sample(smp[1]),
        .overrun(ovr[1]), .clip_count(clp[1])
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every sample_ready must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                if (rdy[d]) begin
                    if (q[d].size() == 0) begin
                        check($sformatf("dut%0d spurious sample_ready", d), rdy[d], 0);
                    end else begin
                        e = q[d].pop_front();
                        check($sformatf("dut%0d sample", d), $signed(smp[d]), e.value);
                        check($sformatf("dut%0d ready cycle", d), cyc, e.at);
                        check($sformatf("dut%0d busy on ready", d), bsy[d], e.busy);
                    end
                end else if (q[d].size() > 0 && q[d][0].at < cyc) begin
                    check($sformatf("dut%0d sample_ready timeout", d), rdy[d], 1);
                    void'(q[d].pop_front());
                end
            end
        end
    end

    task automatic cfg(input int v, input int step, input int wave, input bit en, input bit rs);
        cfg_we      = 1'b1;
        cfg_voice   = 2'(v);
        cfg_step    = 20'(step);
        cfg_wave    = 2'(wave);
        cfg_enable  = en;
        cfg_restart = rs;
        @(negedge clk);
        cfg_we      = 1'b0;
        cfg_restart = 1'b0;
    endtask

    task automatic push(input int ea, input int eb, input logic b);
        q[0].push_back('{value: ea, at: cyc + 7, busy: b});
        q[1].push_back('{value: eb, at: cyc + 7, busy: b});
    endtask

    task automatic request(input int ea, input int eb);
        generate_next = 1'b1;
        push(ea, eb, 1'b0);
        @(negedge clk);
        generate_next = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (q[0].size() > 0 || q[1].size() > 0); i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset sample", d), smp[d], 0);
            check($sformatf("dut%0d reset busy", d), bsy[d], 0);
            check($sformatf("dut%0d reset ready", d), rdy[d], 0);
            check($sformatf("dut%0d reset overrun", d), ovr[d], 0);
            check($sformatf("dut%0d reset clip_count", d), clp[d], 0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Single-voice ramp.
        cfg(0, 'h400, 0, 1'b1, 1'b0);
        request(0, 0);   wait_idle();
        request(32, 8);  wait_idle();
        request(64, 16); wait_idle();

        // Quadrant symmetry.
        cfg(0, 'h80000, 0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            request(qa[i], qb[i]);
            wait_idle();
        end

        // All four voices: saturation at unity gain, in range at GAIN_SHIFT=2.
        for (int v = 0; v < 4; v++) cfg(v, 'h80000, v, 1'b1, 1'b1);
        request(0, 0);          wait_idle();
        request(32767, 16384);  wait_idle();
        request(32767, 32736);  wait_idle();
        request(32767, 16352);  wait_idle();
        check("dut0 clip_count", clp[0], CLIP_A);
        check("dut1 clip_count", clp[1], 0);

        // Disabled voices still advance their phase.
        for (int v = 1; v < 4; v++) cfg(v, 'h80000, 0, 1'b0, 1'b0);
        request(0, 0);             wait_idle();
        request(-16384, -4096);    wait_idle();
        cfg(1, 'h80000, 0, 1'b1, 1'b0);
        request(-32768, -16368);   wait_idle();

        // generate_next held two cycles: one result, overrun set.
        generate_next = 1'b1;
        push(-32704, -8176, 1'b0);
        repeat (2) @(negedge clk);
        generate_next = 1'b0;
        wait_idle();
        check("dut0 overrun after hold", ovr[0], 1);
        check("dut1 overrun after hold", ovr[1], 1);

        // New request on the sample_ready cycle.
        request(0, 0);
        for (int i = 0; i < 20 && !rdy[0]; i++) @(negedge clk);
        check("back-to-back ready seen", rdy[0], 1);
        request(32767, 8192);
        wait_idle();

        // Reset during the second ISSUE cycle discards the request.
        generate_next = 1'b1;
        @(negedge clk);
        generate_next = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d sample in reset", d), smp[d], 0);
            check($sformatf("dut%0d busy in reset", d), bsy[d], 0);
            check($sformatf("dut%0d overrun in reset", d), ovr[d], 0);
            check($sformatf("dut%0d ready in reset", d), rdy[d], 0);
            check($sformatf("dut%0d clip_count in reset", d), clp[d], 0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        cfg(0, 'h400, 0, 1'b1, 1'b0);
        request(0, 0);  wait_idle();
        request(32, 8); wait_idle();
        repeat (3) @(negedge clk);
        check("dut0 sample held", $signed(smp[0]), 32);
        check("dut1 sample held", $signed(smp[1]), 8);
        check("dut0 pending results", q[0].size(), 0);
        check("dut1 pending results", q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
